am_seq16_mul_ctrl: RTL and testbench
====================================

Name: am_seq16_mul_ctrl

Overview:
- Sequencing controller that builds an unsigned 16x16 multiply from four passes through one external 8x8 approximate multiplier (any unsigned_8x8_* variant, combinational or registered).
- Accepts operands over valid/ready, issues the four byte-pair products in a fixed order, shift-accumulates them into a 32-bit result and returns it over valid/ready.
- Sits between the operand source and a single shared multiplier instance so that larger operand widths reuse the characterised 8x8 cores.

Parameters:
MUL_LAT, 0, register stages inside the external multiplier (legal 0..2); mul_z is sampled MUL_LAT cycles after mul_x/mul_y are driven.
CNT_W, 16, width of the completed-operation counter.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  controller can accept operands
a  input  16  multiplicand
b  input  16  multiplier
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
p  output  32  accumulated product, modulo 2^32
mul_x  output  8  byte to multiplier x input
mul_y  output  8  byte to multiplier y input
mul_z  input  16  multiplier product
busy  output  1  high in RUN or DONE
op_cnt  output  CNT_W  completed handshaken results, wraps

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=0 while rst_n=0, then 1 from the first edge after release; out_valid=0, p=0, mul_x=mul_y=0, busy=0, op_cnt=0, step=0, wait counter=0. A reset mid-operation discards the operation; no partial result is ever emitted.
- States:
  - IDLE: in_ready=1.
  - RUN: in_ready=0, busy=1.
  - DONE: out_valid=1, busy=1.
- IDLE: on in_valid&in_ready, latch a,b into internal registers, clear accumulator, step=0, go to RUN. Later changes on a/b have no effect.
- RUN step k drives mul_x/mul_y and holds them for 1+MUL_LAT cycles:
  - k0: a[7:0], b[7:0], shift 0.
  - k1: a[15:8], b[7:0], shift 8.
  - k2: a[7:0], b[15:8], shift 8.
  - k3: a[15:8], b[15:8], shift 16.
- On the last cycle of each step, acc <= acc + (mul_z << shift), truncated to 32 bits. No saturation: approximate products may exceed the exact bound, and they wrap.
- After k3 accumulates: p <= acc result, state DONE, out_valid=1.
- Latency: out_valid rises exactly 4*(1+MUL_LAT) edges after the accepting edge.
- mul_x/mul_y are 0 in IDLE and DONE.
- DONE:
  - p is held stable while out_valid=1 and out_ready=0.
  - On out_valid&out_ready: out_valid<=0, op_cnt<=op_cnt+1 (wraps at 2^CNT_W), state IDLE.
  - in_ready is not asserted in the handshake cycle; there is no bypass. Minimum issue interval is 4*(1+MUL_LAT)+2 cycles.
- in_valid in RUN/DONE is ignored; the source must hold it until in_ready.
- a=0 or b=0 still runs all steps. There is no zero-skip, so latency is constant.

Optional Feature:
Macro AM_SEQ_SKIP_LL_EN.
- Defined: step k0 (low×low) is omitted. Sequence is k1,k2,k3, the accumulator starts at 0, and latency is 3*(1+MUL_LAT). This trades low-order accuracy for one fewer multiplier pass.
- Undefined: all four steps run as above.

Test Plan:
- Bench mul_z = exact mul_x*mul_y, MUL_LAT=0, a=16'h1234, b=16'h5678, out_ready=1 -> out_valid exactly 4 edges after accept, p=32'h06260060, op_cnt=1.
- a=16'hFFFF, b=16'hFFFF, MUL_LAT=2 with a 2-stage registered bench model -> out_valid 12 edges after accept, p=32'hFFFE0001; mul_x/mul_y each held 3 cycles per step in order (FF,FF)x4 with the correct byte pairing.
- Bench forces mul_z=16'hFFFF, any a/b, MUL_LAT=0 -> p=32'h01FFFDFF (wrap mod 2^32), no error flag.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> p and out_valid stable, in_ready=0, a new in_valid is ignored; release -> one handshake, op_cnt +1, in_ready=1 on the next cycle.
- Reset mid-RUN (rst_n low during step k2) -> all outputs zero immediately; after release a fresh a=16'h0002, b=16'h0003 gives p=32'h00000006 with no residue from the prior operation.
- AM_SEQ_SKIP_LL_EN defined, exact bench, a=16'h1234, b=16'h5678, MUL_LAT=0 -> out_valid 3 edges after accept, p=32'h0625E800, first mul_x/mul_y pair = (12,78).

Source files
------------

// File: rtl/am_seq16_mul_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : am_seq16_mul_ctrl_if
// Description : Bundles the signals of the 16x16 sequenced-multiply controller.
//               It carries the operand handshake (in_valid/in_ready, a, b), the
//               result handshake (out_valid/out_ready, p), the byte-pair
//               interface to the shared 8x8 multiplier (mul_x, mul_y, mul_z),
//               and the status outputs (busy, op_cnt).
//               slave  : controller side
//               master : operand source / result sink / multiplier side
// Revision    : 1.0 - initial release
// ============================================================================
interface am_seq16_mul_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      a;
    logic [15:0]      b;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      p;
    logic [7:0]       mul_x;
    logic [7:0]       mul_y;
    logic [15:0]      mul_z;
    logic             busy;
    logic [CNT_W-1:0] op_cnt;

    modport slave (
        input  in_valid, a, b, out_ready, mul_z,
        output in_ready, out_valid, p, mul_x, mul_y, busy, op_cnt
    );

    modport master (
        output in_valid, a, b, out_ready, mul_z,
        input  in_ready, out_valid, p, mul_x, mul_y, busy, op_cnt
    );
endinterface
`default_nettype wire

// File: rtl/am_seq16_mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : am_seq16_mul_ctrl
// Description : Builds an unsigned 16x16 multiply from byte-pair passes through
//               one external 8x8 (approximate) multiplier.
//               Step order: k0 (a_lo,b_lo,<<0), k1 (a_hi,b_lo,<<8),
//                           k2 (a_lo,b_hi,<<8), k3 (a_hi,b_hi,<<16).
//               Each step holds mul_x/mul_y for 1+MUL_LAT cycles and adds
//               mul_z on its last cycle. The accumulator wraps mod 2^32.
// Ports       : clk    - rising-edge clock
//               rst_n  - asynchronous active-low reset
//               bus    - slave modport: operand handshake, result handshake,
//                        multiplier byte interface, busy, op_cnt
// Parameters  : MUL_LAT - register stages in the external multiplier (0..2)
//               CNT_W   - width of the completed-result counter
// Options     : AM_SEQ_SKIP_LL_EN - when defined, step k0 (low x low) is
//               skipped, so only three passes are made.
// Revision    : 1.0 - initial release
// ============================================================================
module am_seq16_mul_ctrl #(
    parameter int MUL_LAT = 0,
    parameter int CNT_W   = 16
) (
    input wire                 clk,
    input wire                 rst_n,
    am_seq16_mul_ctrl_if.slave bus
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_RUN    = 2'd1;
    localparam logic [1:0] c_ST_DONE   = 2'd2;

    localparam logic [1:0] c_LAT       = MUL_LAT[1:0];
    localparam logic [1:0] c_LAST_STEP = 2'd3;
`ifdef AM_SEQ_SKIP_LL_EN
    localparam logic [1:0] c_FIRST_STEP = 2'd1;
`else
    localparam logic [1:0] c_FIRST_STEP = 2'd0;
`endif
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [1:0]       r_step;
    logic [1:0]       r_wait;
    logic [15:0]      r_a;
    logic [15:0]      r_b;
    logic [31:0]      r_acc;
    logic [31:0]      r_p;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;
    logic [7:0]       r_mul_x;
    logic [7:0]       r_mul_y;
    logic [CNT_W-1:0] r_op_cnt;

    // Byte pairing per step: step[0] picks the high byte of a, step[1] the
    // high byte of b. Returns {x, y}.
    function automatic logic [15:0] f_sel_bytes(input logic [1:0]  step,
                                                input logic [15:0] op_a,
                                                input logic [15:0] op_b);
        logic [7:0] x;
        logic [7:0] y;
        x = step[0] ? op_a[15:8] : op_a[7:0];
        y = step[1] ? op_b[15:8] : op_b[7:0];
        return {x, y};
    endfunction

    // Shift is 8 * (number of high bytes in the pair): 0, 8, 8, 16.
    logic [4:0]  w_shift;
    logic [31:0] w_addend;
    logic [31:0] w_acc_next;
    logic [1:0]  w_step_inc;
    logic [15:0] w_next_pair;
    logic [15:0] w_first_pair;
    logic        w_step_end;

    assign w_shift      = {r_step[1] & r_step[0], r_step[1] ^ r_step[0], 3'b000};
    assign w_addend     = {16'd0, bus.mul_z} << w_shift;
    assign w_acc_next   = r_acc + w_addend;
    assign w_step_inc   = r_step + 2'd1;
    assign w_next_pair  = f_sel_bytes(w_step_inc, r_a, r_b);
    assign w_first_pair = f_sel_bytes(c_FIRST_STEP, bus.a, bus.b);
    assign w_step_end   = (r_wait == c_LAT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_step      <= 2'd0;
            r_wait      <= 2'd0;
            r_a         <= 16'd0;
            r_b         <= 16'd0;
            r_acc       <= 32'd0;
            r_p         <= 32'd0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_mul_x     <= 8'd0;
            r_mul_y     <= 8'd0;
            r_op_cnt    <= {CNT_W{1'b0}};
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        // Operands are captured here; a/b are not looked at again.
                        r_a                <= bus.a;
                        r_b                <= bus.b;
                        r_acc              <= 32'd0;
                        r_step             <= c_FIRST_STEP;
                        r_wait             <= 2'd0;
                        {r_mul_x, r_mul_y} <= w_first_pair;
                        r_in_ready         <= 1'b0;
                        r_busy             <= 1'b1;
                        r_state            <= c_ST_RUN;
                    end else begin
                        // Rises on the first edge after reset release.
                        r_in_ready <= 1'b1;
                    end
                end

                c_ST_RUN: begin
                    if (w_step_end) begin
                        r_acc  <= w_acc_next;
                        r_wait <= 2'd0;
                        if (r_step == c_LAST_STEP) begin
                            r_p         <= w_acc_next;
                            r_out_valid <= 1'b1;
                            r_mul_x     <= 8'd0;
                            r_mul_y     <= 8'd0;
                            r_state     <= c_ST_DONE;
                        end else begin
                            r_step             <= w_step_inc;
                            {r_mul_x, r_mul_y} <= w_next_pair;
                        end
                    end else begin
                        r_wait <= r_wait + 2'd1;
                    end
                end

                c_ST_DONE: begin
                    // p stays frozen until the consumer takes it.
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_op_cnt    <= r_op_cnt + c_CNT_ONE;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= c_ST_IDLE;
                    end
                end

                default: begin
                    r_state     <= c_ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b0;
                    r_mul_x     <= 8'd0;
                    r_mul_y     <= 8'd0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.p         = r_p;
    assign bus.mul_x     = r_mul_x;
    assign bus.mul_y     = r_mul_y;
    assign bus.busy      = r_busy;
    assign bus.op_cnt    = r_op_cnt;

endmodule
`default_nettype wire

// File: tb/tb_am_seq16_mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_am_seq16_mul_ctrl
// Description : Self-checking bench for am_seq16_mul_ctrl. Two instances share
//               clk/rst_n: u_dut0 (MUL_LAT=0, combinational exact multiplier,
//               optional forced mul_z=FFFF) and u_dut2 (MUL_LAT=2, two-stage
//               registered exact multiplier). Expected products are queued on
//               issue and popped when out_valid is seen.
//               Honours AM_SEQ_SKIP_LL_EN for expected sequence/values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_am_seq16_mul_ctrl;

`ifdef AM_SEQ_SKIP_LL_EN
    localparam int c_FIRST_STEP = 1;
    localparam bit c_SKIP       = 1'b1;
`else
    localparam int c_FIRST_STEP = 0;
    localparam bit c_SKIP       = 1'b0;
`endif
    localparam int c_N_STEPS = 4 - c_FIRST_STEP;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    am_seq16_mul_ctrl_if #(.CNT_W(16)) bus0 ();
    am_seq16_mul_ctrl_if #(.CNT_W(16)) bus2 ();

    am_seq16_mul_ctrl #(.MUL_LAT(0), .CNT_W(16)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    am_seq16_mul_ctrl #(.MUL_LAT(2), .CNT_W(16)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    // Stimulus, indexed by instance (0 -> u_dut0, 1 -> u_dut2).
    logic        drv_in_valid [2];
    logic [15:0] drv_a        [2];
    logic [15:0] drv_b        [2];
    logic        drv_out_ready[2];
    logic        force_ff;

    assign bus0.in_valid  = drv_in_valid[0];
    assign bus0.a         = drv_a[0];
    assign bus0.b         = drv_b[0];
    assign bus0.out_ready = drv_out_ready[0];
    assign bus2.in_valid  = drv_in_valid[1];
    assign bus2.a         = drv_a[1];
    assign bus2.b         = drv_b[1];
    assign bus2.out_ready = drv_out_ready[1];

    // Multiplier models.
    assign bus0.mul_z = force_ff ? 16'hFFFF : ({8'd0, bus0.mul_x} * {8'd0, bus0.mul_y});

    logic [15:0] pipe1 = 16'd0;
    logic [15:0] pipe2 = 16'd0;
    always @(posedge clk) begin
        pipe1 <= {8'd0, bus2.mul_x} * {8'd0, bus2.mul_y};
        pipe2 <= pipe1;
    end
    assign bus2.mul_z = pipe2;

    // Observed outputs.
    logic        obs_in_ready [2];
    logic        obs_out_valid[2];
    logic        obs_busy     [2];
    logic [31:0] obs_p        [2];
    logic [7:0]  obs_x        [2];
    logic [7:0]  obs_y        [2];
    logic [15:0] obs_cnt      [2];

    assign obs_in_ready[0]  = bus0.in_ready;
    assign obs_out_valid[0] = bus0.out_valid;
    assign obs_busy[0]      = bus0.busy;
    assign obs_p[0]         = bus0.p;
    assign obs_x[0]         = bus0.mul_x;
    assign obs_y[0]         = bus0.mul_y;
    assign obs_cnt[0]       = bus0.op_cnt;
    assign obs_in_ready[1]  = bus2.in_ready;
    assign obs_out_valid[1] = bus2.out_valid;
    assign obs_busy[1]      = bus2.busy;
    assign obs_p[1]         = bus2.p;
    assign obs_x[1]         = bus2.mul_x;
    assign obs_y[1]         = bus2.mul_y;
    assign obs_cnt[1]       = bus2.op_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt [2];

    logic [31:0] sb_q0[$];
    logic [31:0] sb_q1[$];

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference product: exact 16x16 product, minus the low x low partial
    // product when that pass is skipped; with mul_z stuck at FFFF every pass
    // contributes FFFF at its weight (1, 256, 256, 65536).
    function automatic logic [31:0] model_p(input logic [15:0] a, input logic [15:0] b,
                                            input logic ff);
        logic [31:0] full;
        logic [31:0] ll;
        if (ff)
            return 32'h0000FFFF * (c_SKIP ? 32'h00010200 : 32'h00010201);
        full = {16'd0, a} * {16'd0, b};
        ll   = {24'd0, a[7:0]} * {24'd0, b[7:0]};
        return c_SKIP ? (full - ll) : full;
    endfunction

    function automatic logic [15:0] exp_pair(input int k, input logic [15:0] a, input logic [15:0] b);
        case (k)
            0:       return {a[7:0],  b[7:0]};
            1:       return {a[15:8], b[7:0]};
            2:       return {a[7:0],  b[15:8]};
            default: return {a[15:8], b[15:8]};
        endcase
    endfunction

    task automatic check_reset_state(input int idx);
        check_value("rst_in_ready",  32'(obs_in_ready[idx]),  32'd0);
        check_value("rst_out_valid", 32'(obs_out_valid[idx]), 32'd0);
        check_value("rst_p",         obs_p[idx],              32'd0);
        check_value("rst_mul_xy",    32'({obs_x[idx], obs_y[idx]}), 32'd0);
        check_value("rst_busy",      32'(obs_busy[idx]),      32'd0);
        check_value("rst_op_cnt",    32'(obs_cnt[idx]),       32'd0);
    endtask

    // One full transaction: issue, watch the byte pairs, measure latency,
    // optional backpressure, handshake.
    task automatic run_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                          input int bp_cycles, output logic [31:0] p_seen);
        int          lat_per;
        int          edges;
        int          w;
        logic [15:0] pairs[$];
        logic [31:0] exp_p;

        lat_per = (idx == 0) ? 1 : 3;
        p_seen  = 32'd0;
        drv_out_ready[idx] = (bp_cycles == 0);

        w = 0;
        while (!obs_in_ready[idx] && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!obs_in_ready[idx]) begin
            check_value("in_ready_timeout", 32'd0, 32'd1);
            return;
        end

        if (idx == 0) sb_q0.push_back(model_p(a, b, force_ff));
        else          sb_q1.push_back(model_p(a, b, 1'b0));

        drv_in_valid[idx] = 1'b1;
        drv_a[idx]        = a;
        drv_b[idx]        = b;
        @(posedge clk);
        @(negedge clk);
        drv_in_valid[idx] = 1'b0;
        drv_a[idx]        = 16'($urandom);
        drv_b[idx]        = 16'($urandom);
        check_value("run_in_ready", 32'(obs_in_ready[idx]), 32'd0);
        check_value("run_busy",     32'(obs_busy[idx]),     32'd1);

        pairs.push_back({obs_x[idx], obs_y[idx]});
        edges = 0;
        while (edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (obs_out_valid[idx]) break;
            pairs.push_back({obs_x[idx], obs_y[idx]});
        end
        check_value("latency", 32'(edges), 32'(c_N_STEPS * lat_per));

        for (int i = 0; i < pairs.size(); i++) begin
            if (c_FIRST_STEP + i / lat_per <= 3)
                check_value("mul_pair", 32'(pairs[i]), 32'(exp_pair(c_FIRST_STEP + i / lat_per, a, b)));
        end

        if (idx == 0) exp_p = (sb_q0.size() > 0) ? sb_q0.pop_front() : 32'hDEADBEEF;
        else          exp_p = (sb_q1.size() > 0) ? sb_q1.pop_front() : 32'hDEADBEEF;
        p_seen = obs_p[idx];
        check_value("p",         obs_p[idx],                    exp_p);
        check_value("done_xy",   32'({obs_x[idx], obs_y[idx]}), 32'd0);
        check_value("done_busy", 32'(obs_busy[idx]),            32'd1);

        for (int c = 0; c < bp_cycles; c++) begin
            drv_in_valid[idx] = 1'b1;
            drv_a[idx]        = 16'($urandom);
            drv_b[idx]        = 16'($urandom);
            @(negedge clk);
            check_value("bp_p",         obs_p[idx],                exp_p);
            check_value("bp_out_valid", 32'(obs_out_valid[idx]),   32'd1);
            check_value("bp_in_ready",  32'(obs_in_ready[idx]),    32'd0);
        end
        drv_in_valid[idx]  = 1'b0;
        drv_out_ready[idx] = 1'b1;

        @(posedge clk);
        @(negedge clk);
        exp_cnt[idx] = (exp_cnt[idx] + 1) % 65536;
        check_value("post_out_valid", 32'(obs_out_valid[idx]), 32'd0);
        check_value("post_in_ready",  32'(obs_in_ready[idx]),  32'd1);
        check_value("post_busy",      32'(obs_busy[idx]),      32'd0);
        check_value("op_cnt",         32'(obs_cnt[idx]),       32'(exp_cnt[idx]));
    endtask

    initial begin
        logic [31:0] p_seen;

        for (int i = 0; i < 2; i++) begin
            drv_in_valid[i]  = 1'b0;
            drv_a[i]         = 16'd0;
            drv_b[i]         = 16'd0;
            drv_out_ready[i] = 1'b1;
            exp_cnt[i]       = 0;
        end
        force_ff = 1'b0;
        rst_n    = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_state(0);
        check_reset_state(1);
        rst_n = 1'b1;
        #1;
        check_value("release_in_ready_low", 32'(obs_in_ready[0]), 32'd0);
        @(negedge clk);
        check_value("release_in_ready_high", 32'(obs_in_ready[0]), 32'd1);

        // Exact multiplier, MUL_LAT=0.
        run_op(0, 16'h1234, 16'h5678, 0, p_seen);
        check_value("p_1234x5678", p_seen, c_SKIP ? 32'h0625E800 : 32'h06260060);

        // MUL_LAT=2, all-ones operands.
        run_op(1, 16'hFFFF, 16'hFFFF, 0, p_seen);
        check_value("p_ffffxffff", p_seen, c_SKIP ? 32'hFFFD0200 : 32'hFFFE0001);

        // Stuck-high multiplier output: accumulation wraps mod 2^32.
        force_ff = 1'b1;
        run_op(0, 16'($urandom), 16'($urandom), 0, p_seen);
        check_value("p_forced_wrap", p_seen, c_SKIP ? 32'h01FEFE00 : 32'h01FFFDFF);
        force_ff = 1'b0;

        // Backpressure while a new request is offered.
        run_op(0, 16'hBEEF, 16'h0101, 10, p_seen);
        run_op(1, 16'($urandom), 16'($urandom), 3, p_seen);

        // Zero operand still runs every step.
        run_op(0, 16'h0000, 16'hABCD, 0, p_seen);
        run_op(1, 16'h8001, 16'h0000, 0, p_seen);

        for (int i = 0; i < 3; i++) begin
            run_op(0, 16'($urandom), 16'($urandom), 0, p_seen);
            run_op(1, 16'($urandom), 16'($urandom), 0, p_seen);
        end

        // Reset in the middle of step k2 on the MUL_LAT=0 instance.
        while (!obs_in_ready[0]) @(negedge clk);
        drv_in_valid[0] = 1'b1;
        drv_a[0]        = 16'h1234;
        drv_b[0]        = 16'h5678;
        @(posedge clk);
        @(negedge clk);
        drv_in_valid[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_value("k2_pair", 32'({obs_x[0], obs_y[0]}), 32'(c_SKIP ? 16'h1256 : 16'h3456));
        rst_n = 1'b0;
        #1;
        check_reset_state(0);
        check_reset_state(1);
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(0, 16'h0002, 16'h0003, 0, p_seen);
        check_value("p_after_reset", p_seen, 32'h00000006);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
